// File: rtl/alert_pkg.sv
// Shared types and 50 MHz timing defaults for the reminder alert responder.
package alert_pkg;

   typedef enum logic [1:0] {IDLE, ALERT, ESCALATE, SNOOZE} alert_state_t;

   localparam int DEF_DEBOUNCE_CYCLES   = 500_000;
   localparam int DEF_BLINK_HALF_CYCLES = 12_500_000;
   localparam int DEF_ESCALATE_CYCLES   = 500_000_000;
   localparam int DEF_SNOOZE_CYCLES     = 1_500_000_000;
   localparam int DEF_MAX_SNOOZE        = 3;

   localparam int SYNC_STAGES = 2;

   // Bits needed for a counter running 0 .. n-1 (never narrower than one bit).
   function automatic int cnt_w(input int n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage

// File: rtl/btn_debounce.sv
// Active-low push-button debouncer: synchronizes the raw key and emits a one-cycle
// press pulse only on an accepted high-to-low transition.
module btn_debounce
   import alert_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
   input  logic clk,
   input  logic reset,
   input  logic btn_n,
   output logic press
);

   localparam int CW = cnt_w(DEBOUNCE_CYCLES);

   logic [SYNC_STAGES-1:0] sync;
   logic                   stable;
   logic [CW-1:0]          cnt;

   // The counter only runs while the synchronized key disagrees with the accepted level.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync   <= '1;
         stable <= 1'b1;
         cnt    <= '0;
         press  <= 1'b0;
      end else begin
         sync  <= {sync[SYNC_STAGES-2:0], btn_n};
         press <= 1'b0;
         if (sync[SYNC_STAGES-1] == stable) begin
            cnt <= '0;
         end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
            stable <= sync[SYNC_STAGES-1];
            cnt    <= '0;
            press  <= ~sync[SYNC_STAGES-1];
         end else begin
            cnt <= cnt + CW'(1);
         end
      end
   end

endmodule

// File: rtl/reminder_alert.sv
// Reminder alert responder: blinking LED on a remind edge, ack/snooze keys, and an
// escalating buzzer compiled in only when REMINDER_ALERT_BUZZER_EN is defined.
//
// state    | meaning
// IDLE     | nothing pending
// ALERT    | remind seen, LED blinking
// ESCALATE | alert left unanswered, buzzer follows LED
// SNOOZE   | alert muted for SNOOZE_CYCLES
module reminder_alert
   import alert_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES   = DEF_DEBOUNCE_CYCLES,
   parameter int BLINK_HALF_CYCLES = DEF_BLINK_HALF_CYCLES,
   parameter int ESCALATE_CYCLES   = DEF_ESCALATE_CYCLES,
   parameter int SNOOZE_CYCLES     = DEF_SNOOZE_CYCLES,
   parameter int MAX_SNOOZE        = DEF_MAX_SNOOZE
) (
   input  logic                            clk,
   input  logic                            reset,
   input  logic                            remind,
   input  logic                            ack_btn,
   input  logic                            snooze_btn,
   output logic                            led,
   output logic                            buzzer,
   output logic                            alerting,
   output logic                            snoozed,
   output logic [$clog2(MAX_SNOOZE+1)-1:0] snooze_cnt
);

   localparam int SNZ_W = $clog2(MAX_SNOOZE + 1);
   localparam int TMR_W = cnt_w(max3(BLINK_HALF_CYCLES, SNOOZE_CYCLES, ESCALATE_CYCLES));

   alert_state_t           state;
   logic [SYNC_STAGES-1:0] rem_sync;
   logic [SYNC_STAGES-1:0] warm;
   logic                   rem_s, rem_prev, rem_rise;
   logic                   ack_press, snooze_press;
   logic [TMR_W-1:0]       blink_cnt, snz_tmr;
   logic                   in_alert, blink_tc, snz_tc, snz_ok, leave, led_nx, esc_tc;

   btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_ack_db (
      .clk   (clk),
      .reset (reset),
      .btn_n (ack_btn),
      .press (ack_press)
   );

   btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_snooze_db (
      .clk   (clk),
      .reset (reset),
      .btn_n (snooze_btn),
      .press (snooze_press)
   );

   // rem_prev holds 1 until the chain carries real samples, so a remind already
   // high when reset releases reads as a level and never as a rising edge.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rem_sync <= '0;
         warm     <= '0;
         rem_prev <= 1'b1;
      end else begin
         rem_sync <= {rem_sync[SYNC_STAGES-2:0], remind};
         warm     <= {warm[SYNC_STAGES-2:0], 1'b1};
         rem_prev <= warm[SYNC_STAGES-1] ? rem_s : 1'b1;
      end
   end

   assign rem_s    = rem_sync[SYNC_STAGES-1];
   assign rem_rise = rem_s & ~rem_prev;
   assign in_alert = (state == ALERT) || (state == ESCALATE);
   assign blink_tc = (blink_cnt == TMR_W'(BLINK_HALF_CYCLES - 1));
   assign snz_tc   = (snz_tmr == TMR_W'(SNOOZE_CYCLES - 1));
   assign snz_ok   = snooze_press && (snooze_cnt < SNZ_W'(MAX_SNOOZE));
   assign leave    = ~rem_s | ack_press | snz_ok;
   assign led_nx   = led ^ blink_tc;

`ifdef REMINDER_ALERT_BUZZER_EN
   logic [TMR_W-1:0] esc_cnt;

   assign esc_tc = (esc_cnt == TMR_W'(ESCALATE_CYCLES - 1));

   // Held at zero outside ALERT/ESCALATE, so every entry restarts the escalation window.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         esc_cnt <= '0;
         buzzer  <= 1'b0;
      end else begin
         if (!in_alert)
            esc_cnt <= '0;
         else if (!esc_tc)
            esc_cnt <= esc_cnt + TMR_W'(1);
         buzzer <= in_alert & ~leave & esc_tc & led_nx;
      end
   end
`else
   assign esc_tc = 1'b0;
   assign buzzer = 1'b0;
`endif

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= IDLE;
         led        <= 1'b0;
         alerting   <= 1'b0;
         snoozed    <= 1'b0;
         snooze_cnt <= '0;
         blink_cnt  <= '0;
         snz_tmr    <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (rem_rise) begin
                  state      <= ALERT;
                  alerting   <= 1'b1;
                  led        <= 1'b1;
                  blink_cnt  <= '0;
                  snooze_cnt <= '0;
               end
            end
            ALERT, ESCALATE: begin
               if (!rem_s || ack_press) begin
                  state    <= IDLE;
                  alerting <= 1'b0;
                  led      <= 1'b0;
               end else if (snz_ok) begin
                  state      <= SNOOZE;
                  alerting   <= 1'b0;
                  snoozed    <= 1'b1;
                  led        <= 1'b0;
                  snooze_cnt <= snooze_cnt + SNZ_W'(1);
                  snz_tmr    <= '0;
               end else begin
                  led       <= led_nx;
                  blink_cnt <= blink_tc ? '0 : blink_cnt + TMR_W'(1);
                  if (esc_tc)
                     state <= ESCALATE;
               end
            end
            SNOOZE: begin
               if (!rem_s) begin
                  state   <= IDLE;
                  snoozed <= 1'b0;
               end else if (snz_tc) begin
                  state     <= ALERT;
                  snoozed   <= 1'b0;
                  alerting  <= 1'b1;
                  led       <= 1'b1;
                  blink_cnt <= '0;
               end else begin
                  snz_tmr <= snz_tmr + TMR_W'(1);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_reminder_alert.sv
// Bench for reminder_alert: directed episodes plus random remind/key activity, every
// cycle compared against a time-stamp based behavioural model.
module tb_reminder_alert;

   localparam int DB   = 4;
   localparam int BL   = 8;
   localparam int ESC  = 64;
   localparam int SNZ  = 32;
   localparam int MAXS = 2;
   localparam int MAXN = 16384;

`ifdef REMINDER_ALERT_BUZZER_EN
   localparam bit ESC_ON = 1'b1;
`else
   localparam bit ESC_ON = 1'b0;
`endif

   localparam int S_IDLE = 0, S_ALERT = 1, S_ESC = 2, S_SNZ = 3;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       remind = 1'b0;
   logic       ack_btn = 1'b1;
   logic       snooze_btn = 1'b1;
   logic       led, buzzer, alerting, snoozed;
   logic [1:0] snooze_cnt;

   int checks = 0;
   int errors = 0;

   reminder_alert #(
      .DEBOUNCE_CYCLES   (DB),
      .BLINK_HALF_CYCLES (BL),
      .ESCALATE_CYCLES   (ESC),
      .SNOOZE_CYCLES     (SNZ),
      .MAX_SNOOZE        (MAXS)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .remind     (remind),
      .ack_btn    (ack_btn),
      .snooze_btn (snooze_btn),
      .led        (led),
      .buzzer     (buzzer),
      .alerting   (alerting),
      .snoozed    (snoozed),
      .snooze_cnt (snooze_cnt)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   // Model: raw samples per edge since reset release, debounced levels, and
   // episode time stamps from which LED phase and timer expiries are derived.
   bit sr [0:MAXN];
   bit sa [0:MAXN];
   bit ss [0:MAXN];
   int n = 0;
   bit db_a = 1'b1, db_s = 1'b1, pa = 1'b0, ps = 1'b0;
   int m_state = S_IDLE;
   int m_cnt = 0;
   int entry = 0;
   int snz_entry = 0;

   // A key level is accepted once DB consecutive synchronized samples disagree with it.
   function automatic bit window_flips(input int which);
      bit lvl, v;
      lvl = (which == 0) ? db_a : db_s;
      for (int i = n - DB - 1; i <= n - 2; i++) begin
         if (i < 1) v = 1'b1;
         else       v = (which == 0) ? sa[i] : ss[i];
         if (v == lvl) return 1'b0;
      end
      return 1'b1;
   endfunction

   task automatic model_reset();
      n = 0; db_a = 1'b1; db_s = 1'b1; pa = 1'b0; ps = 1'b0;
      m_state = S_IDLE; m_cnt = 0;
   endtask

   task automatic model_step();
      bit use_ack, use_snz, rs, rise;
      n++;
      if (n >= MAXN) begin
         $display("FAIL model_depth got %0d expected below %0d", n, MAXN);
         $fatal(1, "model history exhausted");
      end
      sr[n] = remind; sa[n] = ack_btn; ss[n] = snooze_btn;
      use_ack = pa; use_snz = ps;
      pa = 1'b0; ps = 1'b0;
      if (window_flips(0)) begin db_a = ~db_a; pa = ~db_a; end
      if (window_flips(1)) begin db_s = ~db_s; ps = ~db_s; end
      rs   = (n >= 3) ? sr[n-2] : 1'b0;
      rise = rs && (n >= 4) && !sr[n-3];
      case (m_state)
         S_IDLE: if (rise) begin m_state = S_ALERT; entry = n; m_cnt = 0; end
         S_ALERT, S_ESC: begin
            if (!rs || use_ack) m_state = S_IDLE;
            else if (use_snz && m_cnt < MAXS) begin
               m_state = S_SNZ; snz_entry = n; m_cnt++;
            end else if (ESC_ON && (n - entry >= ESC)) m_state = S_ESC;
         end
         S_SNZ: begin
            if (!rs) m_state = S_IDLE;
            else if (n - snz_entry >= SNZ) begin m_state = S_ALERT; entry = n; end
         end
         default: m_state = S_IDLE;
      endcase
   endtask

   always @(posedge clk) begin
      bit e_al, e_led;
      if (reset) model_step();
      else       model_reset();
      #1;
      e_al  = (m_state == S_ALERT) || (m_state == S_ESC);
      e_led = e_al && (((n - entry) / BL) % 2 == 0);
      check("alerting", alerting, e_al);
      check("snoozed", snoozed, m_state == S_SNZ);
      check("led", led, e_led);
      check("buzzer", buzzer, (m_state == S_ESC) && e_led);
      check("snooze_cnt", snooze_cnt, m_cnt);
   end

   task automatic idle(input int c);
      repeat (c) @(negedge clk);
   endtask

   task automatic press(input int which, input int len);
      if (which == 0) ack_btn = 1'b0;
      else            snooze_btn = 1'b0;
      idle(len);
      ack_btn = 1'b1;
      snooze_btn = 1'b1;
   endtask

   initial begin
      int a_left, s_left;
      idle(3);
      reset = 1'b1;
      idle(10);
      check("rst_led", led, 0);
      check("rst_snooze_cnt", snooze_cnt, 0);

      // alert latency: three edges after remind is first sampled high
      remind = 1'b1;
      repeat (2) @(posedge clk);
      #2 check("lat_early", alerting, 0);
      @(posedge clk);
      #2 check("lat_alert", alerting, 1);
      check("lat_led", led, 1);
      check("lat_buzzer", buzzer, 0);
      idle(75);

      // ack: IDLE seven edges after the key falls, no re-alert while remind stays high
      @(negedge clk);
      ack_btn = 1'b0;
      repeat (6) @(posedge clk);
      #2 check("ack_hold", alerting, 1);
      @(posedge clk);
      #2 check("ack_idle", alerting, 0);
      idle(3);
      ack_btn = 1'b1;
      idle(40);
      check("no_realert", alerting, 0);

      // two snoozes expiring with remind high, third ignored
      remind = 1'b0; idle(6); remind = 1'b1; idle(5);
      press(1, 10); idle(40);
      press(1, 10); idle(40);
      check("snz_two", snooze_cnt, 2);
      press(1, 10); idle(5);
      check("snz_third_cnt", snooze_cnt, 2);
      check("snz_third_alert", alerting, 1);
      check("snz_third_snoozed", snoozed, 0);

      // remind drops during SNOOZE
      remind = 1'b0; idle(6); remind = 1'b1; idle(5);
      press(1, 10);
      remind = 1'b0;
      repeat (2) @(posedge clk);
      #2 check("drop_hold", snoozed, 1);
      @(posedge clk);
      #2 check("drop_idle", snoozed, 0);
      check("drop_led", led, 0);

      // glitchy ack must not be accepted
      idle(4);
      remind = 1'b1; idle(5);
      repeat (5) begin
         ack_btn = 1'b0; idle(2);
         ack_btn = 1'b1; idle(2);
      end
      idle(8);
      check("glitch_alert", alerting, 1);

      // reset in the middle of an escalated alert
      idle(70);
      #3 reset = 1'b0;
      #1;
      check("mid_rst_led", led, 0);
      check("mid_rst_buzzer", buzzer, 0);
      check("mid_rst_alerting", alerting, 0);
      check("mid_rst_snoozed", snoozed, 0);
      check("mid_rst_cnt", snooze_cnt, 0);
      idle(3);
      reset = 1'b1;
      idle(20);
      check("level_no_alert", alerting, 0);

      // random activity
      a_left = 0; s_left = 0;
      for (int cyc = 0; cyc < 4000; cyc++) begin
         @(negedge clk);
         if ($urandom_range(59) == 0) remind = ~remind;
         if (a_left > 0) begin
            a_left--;
            if (a_left == 0) ack_btn = 1'b1;
         end else if ($urandom_range(149) == 0) begin
            a_left = $urandom_range(12, 1); ack_btn = 1'b0;
         end
         if (s_left > 0) begin
            s_left--;
            if (s_left == 0) snooze_btn = 1'b1;
         end else if ($urandom_range(69) == 0) begin
            s_left = $urandom_range(12, 1); snooze_btn = 1'b0;
         end
         if ($urandom_range(1999) == 0) begin
            #3 reset = 1'b0;
            @(negedge clk);
            reset = 1'b1;
         end
      end

      idle(5);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
